// File: rtl/arb2_rr_merge.sv
// Merges two FIFO read ports into one tagged byte stream using bursty round-robin.
// Pops are combinational; read data is captured one cycle after each pop.
module arb2_rr_merge #(
    parameter int MAIN_SIZE = 8,
    parameter int BURST     = 4,
    parameter int CNT_SIZE  = 8
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic [MAIN_SIZE-1:0] in0,
    input  logic [MAIN_SIZE-1:0] in1,
    input  logic                 empty0,
    input  logic                 empty1,
    input  logic                 full,
    output logic                 pop0,
    output logic                 pop1,
    output logic [MAIN_SIZE-1:0] out_data,
    output logic                 out_src,
    output logic                 out_valid,
    output logic [CNT_SIZE-1:0]  cnt0,
    output logic [CNT_SIZE-1:0]  cnt1,
    output logic [1:0]           state_o
);
    localparam int              BC_W    = (BURST > 1) ? $clog2(BURST) : 1;
    localparam logic [BC_W-1:0] BC_LAST = BC_W'(BURST - 1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        S0   = 2'd1,
        S1   = 2'd2
    } state_t;

    state_t          state, state_nxt;
    logic            last, last_nxt;
    logic [BC_W-1:0] burst_cnt, burst_nxt;
    logic            yield0, yield1;
    logic            pend_vld, pend_src;

    assign pop0    = !reset && (state == S0) && !empty0 && !full;
    assign pop1    = !reset && (state == S1) && !empty1 && !full;
    assign yield0  = empty0 || (pop0 && (burst_cnt == BC_LAST));
    assign yield1  = empty1 || (pop1 && (burst_cnt == BC_LAST));
    assign state_o = state;

    always_comb begin
        state_nxt = state;
        last_nxt  = last;
        burst_nxt = burst_cnt;
        case (state)
            IDLE: begin
                if (!empty0 && !empty1) state_nxt = last ? S0 : S1;
                else if (!empty0)       state_nxt = S0;
                else if (!empty1)       state_nxt = S1;
            end
            S0: begin
                if (yield0 && !empty1) begin
                    state_nxt = S1;
                    last_nxt  = 1'b0;
                end else if (yield0 && !empty0) begin
                    burst_nxt = '0;
                end else if (empty0 && empty1) begin
                    state_nxt = IDLE;
                    last_nxt  = 1'b0;
                end else if (pop0) begin
                    burst_nxt = burst_cnt + 1'b1;
                end
            end
            S1: begin
                if (yield1 && !empty0) begin
                    state_nxt = S0;
                    last_nxt  = 1'b1;
                end else if (yield1 && !empty1) begin
                    burst_nxt = '0;
                end else if (empty0 && empty1) begin
                    state_nxt = IDLE;
                    last_nxt  = 1'b1;
                end else if (pop1) begin
                    burst_nxt = burst_cnt + 1'b1;
                end
            end
            default: state_nxt = IDLE;
        endcase
        // A new source always starts a fresh burst.
        if (state_nxt != state) burst_nxt = '0;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state     <= IDLE;
            last      <= 1'b1;
            burst_cnt <= '0;
            pend_vld  <= 1'b0;
            pend_src  <= 1'b0;
            out_valid <= 1'b0;
            out_data  <= '0;
            out_src   <= 1'b0;
            cnt0      <= '0;
            cnt1      <= '0;
        end else begin
            state     <= state_nxt;
            last      <= last_nxt;
            burst_cnt <= burst_nxt;
            pend_vld  <= pop0 || pop1;
            pend_src  <= pop1;
            out_valid <= pend_vld;
            // FIFO read data is valid the cycle after the strobe.
            if (pend_vld) begin
                out_data <= pend_src ? in1 : in0;
                out_src  <= pend_src;
                if (pend_src) cnt1 <= cnt1 + 1'b1;
                else          cnt0 <= cnt0 + 1'b1;
            end
        end
    end
endmodule

// File: tb/tb_arb2_rr_merge.sv
// Self-checking bench for arb2_rr_merge: queue-based FIFO models, delivery scoreboard, directed scenarios.
module tb_arb2_rr_merge;
    localparam int W = 8;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic         reset;
    logic [W-1:0] in0, in1;
    logic         empty0, empty1, full;
    logic         pop0, pop1;
    logic [W-1:0] out_data;
    logic         out_src, out_valid;
    logic [7:0]   cnt0, cnt1;
    logic [1:0]   state_o;

    logic [W-1:0] w_in0, w_in1;
    logic         w_empty0, w_empty1, w_full, w_pop0, w_pop1;
    logic [W-1:0] w_out_data;
    logic         w_out_src, w_out_valid;
    logic [1:0]   w_cnt0, w_cnt1, w_state_o;

    arb2_rr_merge #(.MAIN_SIZE(W), .BURST(4), .CNT_SIZE(8)) u_dut (
        .clk(clk), .reset(reset), .in0(in0), .in1(in1), .empty0(empty0), .empty1(empty1),
        .full(full), .pop0(pop0), .pop1(pop1), .out_data(out_data), .out_src(out_src),
        .out_valid(out_valid), .cnt0(cnt0), .cnt1(cnt1), .state_o(state_o)
    );

    arb2_rr_merge #(.MAIN_SIZE(W), .BURST(4), .CNT_SIZE(2)) u_dut_w (
        .clk(clk), .reset(reset), .in0(w_in0), .in1(w_in1), .empty0(w_empty0), .empty1(w_empty1),
        .full(w_full), .pop0(w_pop0), .pop1(w_pop1), .out_data(w_out_data), .out_src(w_out_src),
        .out_valid(w_out_valid), .cnt0(w_cnt0), .cnt1(w_cnt1), .state_o(w_state_o)
    );

    int checks = 0;
    int failures = 0;

    logic [W-1:0] q0[$];
    logic [W-1:0] q1[$];
    logic         m_pend, m_pend_src;
    logic [W-1:0] m_pend_word, m_data;
    logic         m_src;
    logic [7:0]   m_cnt0, m_cnt1;
    logic         s_p0, s_p1;
    logic [1:0]   s_state;
    int           pop_log[$];
    int           src_log[$];
    logic [W-1:0] data_log[$];

    task automatic model_reset();
        m_pend = 1'b0; m_pend_src = 1'b0; m_pend_word = '0;
        m_data = '0; m_src = 1'b0; m_cnt0 = '0; m_cnt1 = '0;
    endtask

    task automatic push0(input logic [W-1:0] d);
        q0.push_back(d); empty0 = 1'b0;
    endtask

    task automatic push1(input logic [W-1:0] d);
        q1.push_back(d); empty1 = 1'b0;
    endtask

    // One clock: sample strobes at negedge, then after the edge retire the
    // previous pop into the scoreboard and let the FIFO models serve this one.
    task automatic cycle();
        @(negedge clk);
        s_p0 = pop0; s_p1 = pop1; s_state = state_o;
        checks++;
        if ((s_p0 && s_p1) !== 1'b0) begin
            failures++; $display("FAIL both_pops pop0=%b pop1=%b", s_p0, s_p1);
        end
        checks++;
        if ((s_p0 && (empty0 || full)) || (s_p1 && (empty1 || full))) begin
            failures++;
            $display("FAIL illegal_pop pop0=%b pop1=%b empty0=%b empty1=%b full=%b", s_p0, s_p1, empty0, empty1, full);
        end
        checks++;
        if (((s_p0 || s_p1) && s_state == 2'd0) || s_state == 2'd3) begin
            failures++; $display("FAIL state_pop state=%0d pop0=%b pop1=%b", s_state, s_p0, s_p1);
        end
        pop_log.push_back(s_p0 ? 0 : (s_p1 ? 1 : 2));
        @(posedge clk); #1;
        if (m_pend) begin
            m_data = m_pend_word; m_src = m_pend_src;
            if (m_pend_src) m_cnt1 = m_cnt1 + 8'd1;
            else            m_cnt0 = m_cnt0 + 8'd1;
            src_log.push_back(int'(m_pend_src));
            data_log.push_back(m_pend_word);
        end
        checks++;
        if (out_valid !== m_pend) begin
            failures++; $display("FAIL out_valid got=%b exp=%b", out_valid, m_pend);
        end
        checks++;
        if (out_data !== m_data || out_src !== m_src) begin
            failures++; $display("FAIL out_word got=%h/%b exp=%h/%b", out_data, out_src, m_data, m_src);
        end
        checks++;
        if (cnt0 !== m_cnt0 || cnt1 !== m_cnt1) begin
            failures++; $display("FAIL counters got=%0d/%0d exp=%0d/%0d", cnt0, cnt1, m_cnt0, m_cnt1);
        end
        m_pend = s_p0 || s_p1;
        m_pend_src = s_p1;
        if (s_p0 && q0.size() > 0) begin m_pend_word = q0.pop_front(); in0 = m_pend_word; end
        if (s_p1 && q1.size() > 0) begin m_pend_word = q1.pop_front(); in1 = m_pend_word; end
        empty0 = (q0.size() == 0);
        empty1 = (q1.size() == 0);
    endtask

    task automatic apply_reset();
        @(negedge clk); reset = 1'b1; model_reset();
        @(negedge clk); reset = 1'b0;
        @(posedge clk); #1;
    endtask

    task automatic drain();
        full = 1'b0;
        for (int i = 0; i < 40; i++) begin
            cycle();
            if (q0.size() == 0 && q1.size() == 0 && !m_pend) break;
        end
        checks++;
        if (q0.size() != 0 || q1.size() != 0 || m_pend) begin
            failures++; $display("FAIL drain_timeout q0=%0d q1=%0d pend=%b", q0.size(), q1.size(), m_pend);
        end
    endtask

    task automatic clear_logs();
        pop_log.delete(); src_log.delete(); data_log.delete();
    endtask

    task automatic test_reset();
        repeat (2) @(negedge clk);
        checks++;
        if (out_valid !== 1'b0 || out_data !== '0 || out_src !== 1'b0 || cnt0 !== '0 || cnt1 !== '0) begin
            failures++; $display("FAIL reset_outputs valid=%b data=%h src=%b cnt=%0d/%0d", out_valid, out_data, out_src, cnt0, cnt1);
        end
        checks++;
        if (state_o !== 2'd0 || pop0 !== 1'b0 || pop1 !== 1'b0 || w_cnt1 !== 2'd0) begin
            failures++; $display("FAIL reset_state state=%0d pop=%b%b wcnt=%0d exp 0", state_o, pop0, pop1, w_cnt1);
        end
        reset = 1'b0;
        @(posedge clk); #1;
    endtask

    task automatic test_fair();
        int exp_p[12] = '{2, 0, 0, 0, 0, 1, 1, 1, 1, 2, 2, 2};
        int exp_s[8]  = '{0, 0, 0, 0, 1, 1, 1, 1};
        int bad;
        apply_reset();
        for (int i = 0; i < 4; i++) begin push0(W'($urandom)); push1(W'($urandom)); end
        clear_logs();
        repeat (12) cycle();
        bad = -1;
        for (int i = 0; i < 12; i++) if (pop_log[i] != exp_p[i] && bad < 0) bad = i;
        checks++;
        if (bad >= 0) begin
            failures++; $display("FAIL fair_pops idx=%0d got=%0d exp=%0d", bad, pop_log[bad], exp_p[bad]);
        end
        bad = (src_log.size() != 8) ? 99 : -1;
        for (int i = 0; i < 8 && bad < 0; i++) if (src_log[i] != exp_s[i]) bad = i;
        checks++;
        if (bad >= 0) begin
            failures++; $display("FAIL fair_src_seq idx=%0d delivered=%0d exp 8 words 0000 1111", bad, src_log.size());
        end
        checks++;
        if (cnt0 !== 8'd4 || cnt1 !== 8'd4 || s_state !== 2'd0) begin
            failures++; $display("FAIL fair_end cnt=%0d/%0d state=%0d exp 4/4/0", cnt0, cnt1, s_state);
        end
    endtask

    task automatic test_single();
        int exp_p[8] = '{2, 0, 0, 0, 2, 2, 2, 2};
        int bad;
        apply_reset();
        push0(8'hA1); push0(8'hA2); push0(8'hA3);
        clear_logs();
        repeat (8) cycle();
        bad = -1;
        for (int i = 0; i < 8; i++) if (pop_log[i] != exp_p[i] && bad < 0) bad = i;
        checks++;
        if (bad >= 0) begin
            failures++; $display("FAIL single_pops idx=%0d got=%0d exp=%0d", bad, pop_log[bad], exp_p[bad]);
        end
        checks++;
        if (data_log.size() != 3 || data_log[0] !== 8'hA1 || data_log[1] !== 8'hA2 || data_log[2] !== 8'hA3
            || src_log[0] != 0 || src_log[2] != 0) begin
            failures++; $display("FAIL single_data delivered=%0d exp A1,A2,A3 from src 0", data_log.size());
        end
        checks++;
        if (cnt0 !== 8'd3 || cnt1 !== 8'd0 || s_state !== 2'd0) begin
            failures++; $display("FAIL single_end cnt=%0d/%0d state=%0d exp 3/0/0", cnt0, cnt1, s_state);
        end
    endtask

    task automatic test_backpressure();
        full = 1'b1;
        push1(W'($urandom)); push1(W'($urandom));
        cycle();
        for (int i = 0; i < 5; i++) begin
            cycle();
            checks++;
            if (s_p1 !== 1'b0 || s_state !== 2'd2) begin
                failures++; $display("FAIL bp_hold cyc=%0d pop1=%b state=%0d exp 0/2", i, s_p1, s_state);
            end
        end
        full = 1'b0;
        cycle();
        checks++;
        if (s_p1 !== 1'b1) begin
            failures++; $display("FAIL bp_release pop1=%b exp 1", s_p1);
        end
        cycle();
        checks++;
        if (out_valid !== 1'b1 || out_src !== 1'b1) begin
            failures++; $display("FAIL bp_deliver valid=%b src=%b exp 1/1", out_valid, out_src);
        end
        drain();
    endtask

    task automatic test_full_after_pop();
        full = 1'b0;
        push0(W'($urandom)); push0(W'($urandom)); push0(W'($urandom));
        for (int i = 0; i < 10; i++) begin
            cycle();
            if (s_p0) break;
        end
        checks++;
        if (s_p0 !== 1'b1) begin
            failures++; $display("FAIL fap_first_pop pop0=%b exp 1 within 10 cycles", s_p0);
        end
        full = 1'b1;
        cycle();
        checks++;
        if (s_p0 !== 1'b0 || s_p1 !== 1'b0 || out_valid !== 1'b1 || out_src !== 1'b0) begin
            failures++; $display("FAIL fap_deliver pop=%b%b valid=%b src=%b exp 00/1/0", s_p0, s_p1, out_valid, out_src);
        end
        cycle();
        checks++;
        if (s_p0 !== 1'b0 || out_valid !== 1'b0) begin
            failures++; $display("FAIL fap_stall pop0=%b valid=%b exp 0/0", s_p0, out_valid);
        end
        drain();
    endtask

    task automatic test_reset_mid_burst();
        push0(W'($urandom)); push0(W'($urandom)); push0(W'($urandom));
        for (int i = 0; i < 10; i++) begin
            cycle();
            if (s_p0) break;
        end
        checks++;
        if (s_p0 !== 1'b1 || cnt0 === 8'd0) begin
            failures++; $display("FAIL rst_mid_setup pop0=%b cnt0=%0d", s_p0, cnt0);
        end
        reset = 1'b1;
        model_reset();
        #1;
        checks++;
        if (out_valid !== 1'b0 || cnt0 !== 8'd0 || state_o !== 2'd0 || pop0 !== 1'b0) begin
            failures++; $display("FAIL rst_mid_async valid=%b cnt0=%0d state=%0d pop0=%b exp 0", out_valid, cnt0, state_o, pop0);
        end
        @(posedge clk); #1;
        checks++;
        if (out_valid !== 1'b0 || cnt0 !== 8'd0) begin
            failures++; $display("FAIL rst_mid_dropped valid=%b cnt0=%0d exp 0/0", out_valid, cnt0);
        end
        @(negedge clk); reset = 1'b0;
        @(posedge clk); #1;
        drain();
        checks++;
        if (cnt0 !== 8'd2) begin
            failures++; $display("FAIL rst_mid_after cnt0=%0d exp 2", cnt0);
        end
    endtask

    task automatic test_random();
        for (int i = 0; i < 400; i++) begin
            full = ($urandom_range(0, 3) == 0);
            cycle();
            if ($urandom_range(0, 1) == 1 && q0.size() < 4) push0(W'($urandom));
            if ($urandom_range(0, 2) != 0 && q1.size() < 4) push1(W'($urandom));
        end
        drain();
    endtask

    task automatic test_cnt_wrap();
        logic [W-1:0] qw[$];
        logic [1:0]   exp_c[5] = '{2'd1, 2'd2, 2'd3, 2'd0, 2'd1};
        logic         wp, wpend;
        logic [W-1:0] wword;
        int k;
        for (int i = 0; i < 5; i++) qw.push_back(W'($urandom));
        w_empty1 = 1'b0;
        k = 0; wpend = 1'b0; wword = '0;
        for (int c = 0; c < 40 && k < 5; c++) begin
            @(negedge clk);
            wp = w_pop1;
            checks++;
            if (w_pop0 !== 1'b0) begin
                failures++; $display("FAIL wrap_pop0 pop0=%b exp 0", w_pop0);
            end
            @(posedge clk); #1;
            if (wpend) begin
                checks++;
                if (w_out_valid !== 1'b1 || w_cnt1 !== exp_c[k] || w_out_data !== wword) begin
                    failures++; $display("FAIL wrap_cnt word=%0d valid=%b cnt1=%0d exp %0d data=%h exp %h", k, w_out_valid, w_cnt1, exp_c[k], w_out_data, wword);
                end
                k++;
            end
            wpend = wp;
            if (wp && qw.size() > 0) begin wword = qw.pop_front(); w_in1 = wword; end
            w_empty1 = (qw.size() == 0);
        end
        checks++;
        if (k != 5) begin
            failures++; $display("FAIL wrap_timeout delivered=%0d exp 5", k);
        end
    endtask

    initial begin
        reset = 1'b1;
        in0 = '0; in1 = '0; empty0 = 1'b1; empty1 = 1'b1; full = 1'b0;
        w_in0 = '0; w_in1 = '0; w_empty0 = 1'b1; w_empty1 = 1'b1; w_full = 1'b0;
        model_reset();
        test_reset();
        test_fair();
        test_single();
        test_backpressure();
        test_full_after_pop();
        test_reset_mid_burst();
        test_random();
        test_cnt_wrap();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog simulation did not finish");
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures + 1);
        $fatal(1, "watchdog");
    end
endmodule
